// File: rtl/comb_filter_iq_pkg.sv
// Shared definitions for the I/Q comb filter: mode codes and FSM states.
package comb_filter_iq_pkg;

  localparam logic [1:0] MODE_BYPASS   = 2'b00;
  localparam logic [1:0] MODE_FEEDBACK = 2'b01;
  localparam logic [1:0] MODE_FEEDFWD  = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Modes that read and write the delay history (mode 11 behaves as bypass)
  function automatic logic uses_history(input logic [1:0] m);
    return (m == MODE_FEEDBACK) || (m == MODE_FEEDFWD);
  endfunction

endpackage

// File: rtl/comb_filter_iq_sat.sv
// Combinational signed saturator: narrows IN_W to OUT_W bits and flags clipping.
module comb_sat
  import comb_filter_iq_pkg::*;
#(
  parameter int IN_W  = 21,
  parameter int OUT_W = 20
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam logic signed [OUT_W-1:0] MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};

  // Bits from the MSB down to the output sign position must all agree
  logic [IN_W-OUT_W:0] head;
  assign head = din[IN_W-1:OUT_W-1];

  // Clip to the rail matching the input sign when the value does not fit
  always_comb begin
    clip = !((&head) || (~|head));
    dout = din[OUT_W-1:0];
    if (clip) begin
      dout = din[IN_W-1] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/comb_filter_iq.sv
// I/Q comb filter: bypass, feedback comb or feedforward comb with a 2**DELAY_LOG2
// sample history per channel. History is flushed after reset and on mode change.
module comb_filter_iq
  import comb_filter_iq_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int DELAY_LOG2 = 3,
  parameter int FB_SHIFT   = 3,
  parameter int GUARD      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        strobe_in,
  input  logic [1:0]                  mode,
  input  logic signed [BIT_WIDTH-1:0] i_in,
  input  logic signed [BIT_WIDTH-1:0] q_in,
  output logic signed [BIT_WIDTH-1:0] i_out,
  output logic signed [BIT_WIDTH-1:0] q_out,
  output logic                        strobe_out,
  output logic                        sat_flag,
  output logic                        busy
);

  localparam int W     = BIT_WIDTH + GUARD;
  localparam int DEPTH = 1 << DELAY_LOG2;
  localparam int PTR_W = DELAY_LOG2;

  // Reject parameter sets that make the feedback gain or the history meaningless
  generate
    if (FB_SHIFT < 1 || FB_SHIFT > BIT_WIDTH - 1) begin : g_bad_fb_shift
      $error("comb_filter_iq: FB_SHIFT must lie in 1..BIT_WIDTH-1");
    end
    if (DELAY_LOG2 < 1) begin : g_bad_delay
      $error("comb_filter_iq: DELAY_LOG2 must be at least 1");
    end
  endgenerate

  state_t             state_reg;
  logic [PTR_W-1:0]   clr_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [1:0]         mode_reg;
  logic               mode_seen_reg;

  logic                        accept;
  logic                        hist_we;
  logic                        hist_clr;
  logic [PTR_W-1:0]            hist_addr;
  logic signed [BIT_WIDTH-1:0] x_ch [2];
  logic signed [BIT_WIDTH-1:0] y_ch [2];
  logic [1:0]                  clip_ch;

  assign x_ch[0] = i_in;
  assign x_ch[1] = q_in;

  // A sample is consumed only in RUN, enabled, and with the mode unchanged
  assign accept = enable && strobe_in && (state_reg == ST_RUN) && (mode == mode_reg);

  // History write port: zero fill while clearing, sample store while running
  always_comb begin
    hist_we   = 1'b0;
    hist_clr  = 1'b0;
    hist_addr = wr_ptr_reg;
    if (enable && state_reg == ST_CLEAR) begin
      hist_we   = 1'b1;
      hist_clr  = 1'b1;
      hist_addr = clr_ptr_reg;
    end else if (accept && uses_history(mode_reg)) begin
      hist_we   = 1'b1;
    end
  end

  // Identical datapath for I (gi=0) and Q (gi=1), sharing one pointer
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [W-1:0]          hist_mem [DEPTH];
      logic signed [W-1:0]   x_ext;
      logic signed [W-1:0]   h_val;
      logic signed [W-1:0]   h_shr;
      logic signed [W:0]     pre;
      logic signed [W-1:0]   s_w;
      logic signed [W-1:0]   wr_data;
      logic                  clip_w;
      logic                  clip_o;

      assign x_ext = {{GUARD{x_ch[gi][BIT_WIDTH-1]}}, x_ch[gi]};
      // Asynchronous read: the value stored D samples ago sits at the write slot,
      // and back-to-back strobes need it in the same cycle as the write
      assign h_val = hist_mem[wr_ptr_reg];
      assign h_shr = h_val >>> FB_SHIFT;

      // Select the comb function at W+1 bits so the sum or difference cannot wrap
      always_comb begin
        case (mode_reg)
          MODE_FEEDBACK: pre = {x_ext[W-1], x_ext} + {h_shr[W-1], h_shr};
          MODE_FEEDFWD:  pre = {x_ext[W-1], x_ext} - {h_val[W-1], h_val};
          default:       pre = {x_ext[W-1], x_ext};
        endcase
      end

      comb_sat #(.IN_W(W + 1), .OUT_W(W)) u_sat_int (
        .din  (pre),
        .dout (s_w),
        .clip (clip_w)
      );

      comb_sat #(.IN_W(W), .OUT_W(BIT_WIDTH)) u_sat_out (
        .din  (s_w),
        .dout (y_ch[gi]),
        .clip (clip_o)
      );

      assign clip_ch[gi] = clip_w | clip_o;

      // Feedback recirculates the saturated result; feedforward keeps the raw input
      always_comb begin
        if (hist_clr) begin
          wr_data = '0;
        end else if (mode_reg == MODE_FEEDBACK) begin
          wr_data = s_w;
        end else begin
          wr_data = x_ext;
        end
      end

      // History RAM write, no reset so it maps onto memory primitives
      always_ff @(posedge clock) begin
        if (hist_we) begin
          hist_mem[hist_addr] <= wr_data;
        end
      end
    end
  endgenerate

  // Control FSM with registered outputs: flush sequencing, mode tracking, sample issue
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_CLEAR;
      clr_ptr_reg   <= '0;
      wr_ptr_reg    <= '0;
      mode_reg      <= MODE_BYPASS;
      mode_seen_reg <= 1'b0;
      i_out         <= '0;
      q_out         <= '0;
      strobe_out    <= 1'b0;
      sat_flag      <= 1'b0;
      busy          <= 1'b1;
    end else begin
      strobe_out <= 1'b0;
      if (enable) begin
        case (state_reg)
          ST_CLEAR: begin
            if (mode_seen_reg && mode != mode_reg) begin
              // Mode moved during the flush: adopt it and start over
              mode_reg    <= mode;
              clr_ptr_reg <= '0;
            end else begin
              // First clock after reset adopts the mode without restarting
              mode_reg      <= mode;
              mode_seen_reg <= 1'b1;
              if (clr_ptr_reg == PTR_W'(DEPTH - 1)) begin
                state_reg   <= ST_RUN;
                clr_ptr_reg <= '0;
                wr_ptr_reg  <= '0;
                busy        <= 1'b0;
              end else begin
                clr_ptr_reg <= clr_ptr_reg + PTR_W'(1);
              end
            end
          end
          ST_RUN: begin
            if (mode != mode_reg) begin
              mode_reg    <= mode;
              state_reg   <= ST_CLEAR;
              clr_ptr_reg <= '0;
              busy        <= 1'b1;
            end else if (strobe_in) begin
              i_out      <= y_ch[0];
              q_out      <= y_ch[1];
              sat_flag   <= |clip_ch;
              strobe_out <= 1'b1;
              wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
          end
          default: begin
            state_reg <= ST_CLEAR;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comb_filter_iq.sv
// Self-checking bench for comb_filter_iq: sample-level model plus directed literals.
module tb_comb_filter_iq;

  localparam int BW    = 16;
  localparam int DL2   = 3;
  localparam int D     = 8;
  localparam int FB    = 3;
  localparam int GUARD = 4;
  localparam int W     = BW + GUARD;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b1;
  logic                 strobe_in = 1'b0;
  logic [1:0]           mode = 2'b00;
  logic signed [BW-1:0] i_in = '0;
  logic signed [BW-1:0] q_in = '0;
  logic signed [BW-1:0] i_out;
  logic signed [BW-1:0] q_out;
  logic                 strobe_out;
  logic                 sat_flag;
  logic                 busy;

  comb_filter_iq #(
    .BIT_WIDTH  (BW),
    .DELAY_LOG2 (DL2),
    .FB_SHIFT   (FB),
    .GUARD      (GUARD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .strobe_in  (strobe_in),
    .mode       (mode),
    .i_in       (i_in),
    .q_in       (q_in),
    .i_out      (i_out),
    .q_out      (q_out),
    .strobe_out (strobe_out),
    .sat_flag   (sat_flag),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_clear = D;
  int m_mode = 0;
  bit m_valid = 1'b0;
  int st_i[$];
  int st_q[$];
  int exp_i = 0;
  int exp_q = 0;
  bit exp_strobe = 1'b0;
  bit exp_sat = 1'b0;
  bit exp_busy = 1'b1;

  function automatic int clampv(input int v, input int bits);
    int hi;
    int lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // y: output, store: value kept in history, clip: any saturation
  function automatic void chan(input int x, input int h, input int md,
                               output int y, output int store, output bit clip);
    int s;
    if (md == 1) begin
      s     = x + floor_div(h, 1 << FB);
      store = clampv(s, W);
      y     = clampv(store, BW);
      clip  = (store != s) || (y != store);
    end else if (md == 2) begin
      s     = x - h;
      store = x;
      y     = clampv(clampv(s, W), BW);
      clip  = (y != s);
    end else begin
      y     = x;
      store = 0;
      clip  = 1'b0;
    end
  endfunction

  task automatic model_reset();
    m_clear    = D;
    m_mode     = 0;
    m_valid    = 1'b0;
    st_i.delete();
    st_q.delete();
    exp_i      = 0;
    exp_q      = 0;
    exp_strobe = 1'b0;
    exp_sat    = 1'b0;
    exp_busy   = 1'b1;
  endtask

  task automatic model_step();
    int n, hi, hq, yi, yq, si, sq;
    bit ci, cq;
    exp_strobe = 1'b0;
    if (enable) begin
      if (m_clear > 0) begin
        if (m_valid && int'(mode) != m_mode) begin
          m_mode  = int'(mode);
          m_clear = D;
        end else begin
          m_mode  = int'(mode);
          m_valid = 1'b1;
          m_clear = m_clear - 1;
        end
        st_i.delete();
        st_q.delete();
      end else if (int'(mode) != m_mode) begin
        m_mode  = int'(mode);
        m_clear = D;
      end else if (strobe_in) begin
        n  = st_i.size();
        hi = (n >= D) ? st_i[n - D] : 0;
        hq = (n >= D) ? st_q[n - D] : 0;
        chan(int'(i_in), hi, m_mode, yi, si, ci);
        chan(int'(q_in), hq, m_mode, yq, sq, cq);
        if (m_mode == 1 || m_mode == 2) begin
          st_i.push_back(si);
          st_q.push_back(sq);
        end
        exp_i      = yi;
        exp_q      = yq;
        exp_sat    = ci | cq;
        exp_strobe = 1'b1;
      end
    end
    exp_busy = (m_clear > 0);
  endtask

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process ----------------
  int log_i[$];
  int log_q[$];
  int n_out = 0;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("busy", int'(busy), int'(exp_busy));
        check("strobe_out", int'(strobe_out), int'(exp_strobe));
        check("i_out", int'(i_out), exp_i);
        check("q_out", int'(q_out), exp_q);
        if (exp_strobe && strobe_out) check("sat_flag", int'(sat_flag), int'(exp_sat));
        if (strobe_out) begin
          log_i.push_back(int'(i_out));
          log_q.push_back(int'(q_out));
          $display("out %0d mode=%0d i=%0d q=%0d sat=%0b", n_out, mode, i_out, q_out, sat_flag);
          n_out++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int i, input int q, input int gap);
    strobe_in = 1'b1;
    i_in      = BW'(i);
    q_in      = BW'(q);
    tick();
    strobe_in = 1'b0;
    repeat (gap) tick();
  endtask

  // Change mode and wait (bounded) for the flush to complete
  task automatic enter_mode(input logic [1:0] m);
    mode = m;
    tick();
    for (int k = 0; k < 40 && busy; k++) tick();
    check("flush_done", int'(busy), 0);
  endtask

  // Count cycles busy is high; returns at the negedge it first drops
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (busy) n++;
      else if (n > 0) break;
    end
  endtask

  int n_busy;

  initial begin
    // 1. Reset values and the post-reset flush
    repeat (3) tick();
    check("rst_busy", int'(busy), 1);
    check("rst_i_out", int'(i_out), 0);
    check("rst_q_out", int'(q_out), 0);
    check("rst_strobe_out", int'(strobe_out), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    strobe_in = 1'b1;
    i_in      = 16'sd555;
    reset     = 1'b0;
    count_busy(n_busy);
    strobe_in = 1'b0;
    check("reset_flush_len", n_busy, 8);
    check("no_out_during_flush", log_i.size(), 0);

    // Mode change while flushing restarts the flush
    mode = 2'b10;
    repeat (3) tick();
    mode = 2'b01;
    count_busy(n_busy);
    check("restart_flush_len", n_busy, 9);

    // 2. Feedback impulse, strobe every 4 clocks
    tick();
    log_i.delete();
    log_q.delete();
    send(8192, -8192, 3);
    for (int k = 1; k < 49; k++) send(0, 0, 3);
    check("fb_count", log_i.size(), 49);
    check("fb_i0", log_i[0], 8192);
    check("fb_i1", log_i[1], 0);
    check("fb_i8", log_i[8], 1024);
    check("fb_i16", log_i[16], 128);
    check("fb_i24", log_i[24], 16);
    check("fb_i32", log_i[32], 2);
    check("fb_i40", log_i[40], 0);
    check("fb_q0", log_q[0], -8192);
    check("fb_q8", log_q[8], -1024);
    check("fb_q32", log_q[32], -2);
    check("fb_q40", log_q[40], -1);
    check("fb_q41", log_q[41], 0);
    check("fb_q48", log_q[48], -1);

    // 3. Feedforward step, back-to-back strobes
    enter_mode(2'b10);
    log_i.delete();
    log_q.delete();
    for (int k = 0; k < 16; k++) send(1000, 0, 0);
    tick();
    check("ff_i0", log_i[0], 1000);
    check("ff_i7", log_i[7], 1000);
    check("ff_i8", log_i[8], 0);
    check("ff_i15", log_i[15], 0);

    // 4. Feedback DC at both rails
    enter_mode(2'b01);
    for (int k = 0; k < 80; k++) send(32767, 0, 0);
    tick();
    check("dc_pos_i", int'(i_out), 32767);
    check("dc_pos_sat", int'(sat_flag), 1);
    for (int k = 0; k < 100; k++) send(-32768, 0, 0);
    tick();
    check("dc_neg_i", int'(i_out), -32768);
    check("dc_neg_sat", int'(sat_flag), 1);

    // 5. Switch feedback -> feedforward mid-stream with strobes held
    send(8192, 0, 0);
    for (int k = 0; k < 3; k++) send(0, 0, 0);
    mode      = 2'b10;
    strobe_in = 1'b1;
    i_in      = 16'sd7777;
    count_busy(n_busy);
    strobe_in = 1'b0;
    check("switch_flush_len", n_busy, 8);
    log_i.delete();
    log_q.delete();
    send(500, 0, 0);
    for (int k = 0; k < 9; k++) send(0, 0, 0);
    tick();
    check("sw_i0", log_i[0], 500);
    check("sw_i1", log_i[1], 0);
    check("sw_i8", log_i[8], -500);
    check("sw_i9", log_i[9], 0);

    // 6. Bypass, then enable=0 freezing the feedforward history
    enter_mode(2'b00);
    log_i.delete();
    log_q.delete();
    send(1234, -77, 1);
    send(-32768, 32767, 1);
    check("byp_i0", log_i[0], 1234);
    check("byp_q0", log_q[0], -77);
    check("byp_i1", log_i[1], -32768);
    check("byp_q1", log_q[1], 32767);

    enter_mode(2'b10);
    log_i.delete();
    log_q.delete();
    send(100, 0, 0);
    send(200, 0, 0);
    send(300, 0, 0);
    tick();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) send(999, 999, 0);
    tick();
    check("disabled_no_output", log_i.size(), 3);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) send(0, 0, 0);
    tick();
    check("en_i5", log_i[5], 0);
    check("en_i8", log_i[8], -100);

    // Reset asserted mid-operation takes effect without a clock edge
    send(4321, 11, 0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_busy", int'(busy), 1);
    check("async_i_out", int'(i_out), 0);
    check("async_q_out", int'(q_out), 0);
    check("async_strobe", int'(strobe_out), 0);
    tick();
    tick();
    reset = 1'b0;
    mode  = 2'b00;
    count_busy(n_busy);
    check("post_reset_flush_len", n_busy, 8);
    send(42, -42, 1);
    check("post_reset_byp", int'(i_out), 42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
